uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver. It captures one {status, data} entry per received frame and stores it in a first-word-fall-through FIFO. Entries are presented to the host side through a valid/ready handshake, together with occupancy, full/empty and sticky overrun flags. The receiver's FIFO write enable is a level held for the whole READY state (several i_clk cycles), so this block edge-detects it to produce exactly one write per frame.

Parameters:
DataLength, 8, width of the received data word; must match the receiver.
Depth, 16, number of entries; power of two, >= 2.
StatusWidth, 2, width of the per-frame status field: {frame error, parity error}.

Ports:
i_clk  in  1  clock, baud rate x oversampling (same clock as the receiver)
i_rst_n  in  1  reset; asynchronous, active-low
i_wr_en  in  1  receiver FIFO write enable; level, may stay high for multiple cycles
i_wr_data  in  DataLength  received data word, stable while i_wr_en is high
i_wr_status  in  StatusWidth  {frame error, parity error}, stable while i_wr_en is high
o_rd_valid  out  1  head entry available
i_rd_ready  in  1  consumer accepts the head entry
o_rd_data  out  DataLength  head entry data
o_rd_status  out  StatusWidth  head entry status
o_count  out  $clog2(Depth)+1  number of stored entries, 0..Depth
o_full  out  1  o_count == Depth
o_empty  out  1  o_count == 0
o_overrun  out  1  sticky flag: a frame was dropped because the FIFO was full
i_overrun_clr  in  1  clears o_overrun

Behaviour:
- Reset (async, active-low):
  - Read and write pointers = 0, o_count = 0, o_empty = 1, o_full = 0, o_rd_valid = 0, o_overrun = 0.
  - wr_en_q = 1, so an i_wr_en held high across reset release does not write.
  - Storage array is not reset. o_rd_data and o_rd_status are don't-care while o_rd_valid = 0.
  - Reset mid-operation discards all entries immediately.
- Write detect:
  - wr_pulse = i_wr_en & ~wr_en_q; wr_en_q <= i_wr_en every cycle.
  - Result: one push per rising edge of i_wr_en, regardless of how long the level is held.
- Push:
  - On wr_pulse with the FIFO not full, or full with a pop in the same cycle, write {i_wr_status, i_wr_data} at the write pointer and advance it.
  - Latency: entry is visible (o_rd_valid = 1, o_empty = 0) after the clock edge ending the first cycle i_wr_en is high, i.e. 1 cycle.
- Pop:
  - Occurs when o_rd_valid & i_rd_ready; advance the read pointer.
  - o_rd_data and o_rd_status are read combinationally at the read pointer (FWFT); the next entry is visible the following cycle.
- Simultaneous push and pop:
  - Full: both occur; o_count stays at Depth; no overrun.
  - Empty: o_rd_valid = 0, so there is no pop; push only, o_count becomes 1.
  - Otherwise: both occur; o_count is unchanged.
- Overrun:
  - wr_pulse while full with no pop: entry dropped, existing contents untouched, o_overrun <= 1.
  - o_overrun holds until i_overrun_clr. If a set and a clear occur in the same cycle, the set wins.
- Pointers and flags:
  - Pointers are $clog2(Depth)+1 bits; the MSB is the wrap bit, and wrap-around is natural binary rollover.
  - full = (MSBs differ) & (lower bits equal). empty = pointers equal.
  - o_count = wr_ptr - rd_ptr, modulo 2^($clog2(Depth)+1).
  - All flags are registered-pointer derived; no combinational path from i_wr_en to the outputs.
- No FSM beyond the pointer counters, the edge-detect register and the sticky flag.

Decomposition:
- Package uart_pkg:
  - StatusWidth = 2.
  - Index constants STATUS_PARITY = 0, STATUS_FRAME = 1.
  - Default DataLength and Depth.
- Sub-module uart_fifo_mem: Depth x (StatusWidth+DataLength) register array, one synchronous write port, one asynchronous read port.
- Pointer, flag, edge-detect and overrun logic live in uart_rx_fifo.

Test Plan:
- Reset, then i_wr_en high 5 cycles with data 8'hA5, status 2'b00 -> exactly one entry; o_count = 1 and o_rd_valid = 1 one cycle after i_wr_en rises; o_rd_data = 8'hA5. Pop -> o_empty = 1.
- Write frames 8'h00..8'h0F (Depth 16), then 8'hFF -> o_full = 1, o_count = 16, o_overrun = 1. Drain with i_rd_ready = 1 -> 8'h00..8'h0F in order; 8'hFF never appears.
- Full FIFO, write pulse in the same cycle as a pop -> o_count stays 16, o_overrun stays 0, new word is last out. Empty FIFO, write pulse with i_rd_ready = 1 -> o_count = 1, no pop.
- Frame 8'h3C with status 2'b10, then 8'h3D with status 2'b01 -> o_rd_status 2'b10 then 2'b01, paired with the correct data.
- o_overrun = 1; overrun and i_overrun_clr in the same cycle -> stays 1. i_overrun_clr alone -> 0 on the next cycle.
- 5 entries stored, i_rst_n pulsed low mid-stream with i_wr_en held high across release -> immediately o_empty = 1, o_count = 0, o_overrun = 0; no write on release; the next i_wr_en rising edge writes exactly one entry.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: status field layout and default sizing.
package uart_pkg;

  localparam int unsigned StatusWidth = 2;

  // Bit positions inside the per-frame status field {frame error, parity error}
  localparam int unsigned STATUS_PARITY = 0;
  localparam int unsigned STATUS_FRAME  = 1;

  localparam int unsigned DefaultDataLength = 8;
  localparam int unsigned DefaultDepth      = 16;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the receive FIFO: one synchronous write port, one asynchronous read port.
module uart_fifo_mem #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AddrW-1:0] i_waddr,
  input  logic [Width-1:0] i_wdata,
  input  logic [AddrW-1:0] i_raddr,
  output logic [Width-1:0] o_rdata
);

  logic [Width-1:0] mem [Depth];

  // Contents are intentionally not reset; readers qualify with valid.
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer: one {status, data} entry per received frame,
// with edge-detected write, valid/ready read side, occupancy flags and sticky overrun.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DataLength  = DefaultDataLength,
  parameter int unsigned Depth       = DefaultDepth,
  parameter int unsigned StatusWidth = uart_pkg::StatusWidth
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_en,
  input  logic [DataLength-1:0]  i_wr_data,
  input  logic [StatusWidth-1:0] i_wr_status,
  output logic                   o_rd_valid,
  input  logic                   i_rd_ready,
  output logic [DataLength-1:0]  o_rd_data,
  output logic [StatusWidth-1:0] o_rd_status,
  output logic [$clog2(Depth):0] o_count,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_overrun,
  input  logic                   i_overrun_clr
);

  localparam int unsigned AddrW  = $clog2(Depth);
  localparam int unsigned PtrW   = AddrW + 1;
  localparam int unsigned EntryW = StatusWidth + DataLength;

  logic [PtrW-1:0]   wr_ptr;
  logic [PtrW-1:0]   rd_ptr;
  logic              wr_en_q;
  logic              overrun_q;
  logic              full;
  logic              empty;
  logic              wr_pulse;
  logic              pop;
  logic              push;
  logic              drop;
  logic [EntryW-1:0] rd_entry;

  // Flags come only from the registered pointers
  assign full  = (wr_ptr[AddrW] != rd_ptr[AddrW]) && (wr_ptr[AddrW-1:0] == rd_ptr[AddrW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // The receiver holds its write enable for a whole state; only its rising edge is a frame
  assign wr_pulse = i_wr_en & ~wr_en_q;
  assign pop      = ~empty & i_rd_ready;
  assign push     = wr_pulse & (~full | pop);
  assign drop     = wr_pulse & full & ~pop;

  // wr_en_q resets high so a level already asserted at reset release is not taken as a frame
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wr_en_q   <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      wr_en_q <= i_wr_en;
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      if (drop)               overrun_q <= 1'b1;
      else if (i_overrun_clr) overrun_q <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .Width (EntryW),
    .Depth (Depth)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (push),
    .i_waddr (wr_ptr[AddrW-1:0]),
    .i_wdata ({i_wr_status, i_wr_data}),
    .i_raddr (rd_ptr[AddrW-1:0]),
    .o_rdata (rd_entry)
  );

  assign o_rd_valid  = ~empty;
  assign o_rd_data   = rd_entry[DataLength-1:0];
  assign o_rd_status = rd_entry[EntryW-1:DataLength];
  assign o_count     = wr_ptr - rd_ptr;
  assign o_full      = full;
  assign o_empty     = empty;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DataLength 8, Depth 16).
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [1:0] wr_status;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic [1:0] rd_status;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overrun;
  logic       overrun_clr;

  int vectors = 0;
  int errors  = 0;

  uart_rx_fifo #(
    .DataLength  (8),
    .Depth       (16),
    .StatusWidth (2)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_wr_en       (wr_en),
    .i_wr_data     (wr_data),
    .i_wr_status   (wr_status),
    .o_rd_valid    (rd_valid),
    .i_rd_ready    (rd_ready),
    .o_rd_data     (rd_data),
    .o_rd_status   (rd_status),
    .o_count       (count),
    .o_full        (full),
    .o_empty       (empty),
    .o_overrun     (overrun),
    .i_overrun_clr (overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_frame(input logic [7:0] d, input logic [1:0] s);
    wr_data   = d;
    wr_status = s;
    wr_en     = 1'b1;
    step();
    wr_en     = 1'b0;
    step();
  endtask

  initial begin
    rst_n       = 1'b0;
    wr_en       = 1'b0;
    wr_data     = '0;
    wr_status   = '0;
    rd_ready    = 1'b0;
    overrun_clr = 1'b0;
    step();
    step();
    chk("reset_count",   32'(count),    0);
    chk("reset_empty",   32'(empty),    1);
    chk("reset_full",    32'(full),     0);
    chk("reset_valid",   32'(rd_valid), 0);
    chk("reset_overrun", 32'(overrun),  0);
    rst_n = 1'b1;
    step();

    // Level held 5 cycles produces exactly one entry
    wr_data   = 8'hA5;
    wr_status = 2'b00;
    wr_en     = 1'b1;
    step();
    chk("lvl_count1", 32'(count),    1);
    chk("lvl_valid",  32'(rd_valid), 1);
    chk("lvl_data",   32'(rd_data),  32'h A5);
    for (int i = 0; i < 4; i++) step();
    chk("lvl_count_held", 32'(count), 1);
    wr_en    = 1'b0;
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("lvl_pop_empty", 32'(empty), 1);

    // Fill, overflow, drain in order
    for (int i = 0; i < 16; i++) write_frame(8'(i), 2'b00);
    chk("fill_full",    32'(full),    1);
    chk("fill_count",   32'(count),   16);
    chk("fill_no_ovr",  32'(overrun), 0);
    write_frame(8'hFF, 2'b00);
    chk("ovf_overrun", 32'(overrun), 1);
    chk("ovf_count",   32'(count),   16);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", 32'(rd_valid), 1);
      chk("drain_data",  32'(rd_data),  32'(i));
      step();
    end
    rd_ready = 1'b0;
    chk("drain_empty", 32'(empty), 1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("clr_overrun", 32'(overrun), 0);

    // Full FIFO: push and pop in the same cycle
    for (int i = 0; i < 16; i++) write_frame(8'(8'h10 + i), 2'b00);
    wr_data  = 8'hEE;
    wr_en    = 1'b1;
    rd_ready = 1'b1;
    step();
    wr_en    = 1'b0;
    rd_ready = 1'b0;
    chk("fullpp_count",   32'(count),   16);
    chk("fullpp_overrun", 32'(overrun), 0);
    step();
    rd_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("fullpp_data", 32'(rd_data), 32'(8'h10 + i));
      step();
    end
    chk("fullpp_last", 32'(rd_data), 32'h EE);
    step();
    chk("fullpp_empty", 32'(empty), 1);

    // Empty FIFO: push with ready high, no pop that cycle
    wr_data = 8'h77;
    wr_en   = 1'b1;
    step();
    chk("emptypp_count", 32'(count),   1);
    chk("emptypp_data",  32'(rd_data), 32'h77);
    wr_en = 1'b0;
    step();
    rd_ready = 1'b0;
    chk("emptypp_popped", 32'(empty), 1);

    // Status travels with its data
    write_frame(8'h3C, 2'b10);
    write_frame(8'h3D, 2'b01);
    chk("stat0_status", 32'(rd_status), 32'(2'b10));
    chk("stat0_frame",  32'(rd_status[STATUS_FRAME]), 1);
    chk("stat0_data",   32'(rd_data),   32'h3C);
    rd_ready = 1'b1;
    step();
    chk("stat1_status", 32'(rd_status), 32'(2'b01));
    chk("stat1_parity", 32'(rd_status[STATUS_PARITY]), 1);
    chk("stat1_data",   32'(rd_data),   32'h3D);
    step();
    rd_ready = 1'b0;
    chk("stat_empty", 32'(empty), 1);

    // Overrun set beats clear; clear alone clears
    for (int i = 0; i < 16; i++) write_frame(8'(8'h40 + i), 2'b00);
    write_frame(8'hFE, 2'b00);
    chk("ovr_set", 32'(overrun), 1);
    wr_data     = 8'hFD;
    wr_en       = 1'b1;
    overrun_clr = 1'b1;
    step();
    wr_en       = 1'b0;
    overrun_clr = 1'b0;
    chk("ovr_set_wins", 32'(overrun), 1);
    step();
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 0);
    write_frame(8'hFC, 2'b00);
    chk("ovr_reset_prep", 32'(overrun), 1);
    chk("ovr_head_kept",  32'(rd_data), 32'h40);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) step();
    rd_ready = 1'b0;
    chk("ovr_drain_empty", 32'(empty), 1);

    // Reset mid-stream with the write level held across release
    for (int i = 0; i < 5; i++) write_frame(8'(8'h60 + i), 2'b00);
    chk("mid_count5", 32'(count), 5);
    wr_data = 8'h5A;
    wr_en   = 1'b1;
    rst_n   = 1'b0;
    #1;
    chk("mid_rst_empty",   32'(empty),    1);
    chk("mid_rst_count",   32'(count),    0);
    chk("mid_rst_overrun", 32'(overrun),  0);
    chk("mid_rst_valid",   32'(rd_valid), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("rel_no_write", 32'(count), 0);
    step();
    chk("rel_no_write2", 32'(count), 0);
    wr_en = 1'b0;
    step();
    wr_en = 1'b1;
    step();
    chk("rel_next_edge", 32'(count),   1);
    chk("rel_data",      32'(rd_data), 32'h5A);
    step();
    step();
    wr_en = 1'b0;
    chk("rel_single", 32'(count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
